vga_sync_gen: RTL and testbench
===============================

VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

Interface
REQ-001 SHALL have parameter FDivider, default 83: PLL feedback divider (DIVF); VCO = clk*(FDivider+1).
REQ-002 SHALL have parameter QDivider, default 5: PLL output divider (DIVQ); px_clk = clk*(FDivider+1)/2^QDivider (31.5 MHz from 12 MHz).
REQ-003 SHALL have parameters activeHvideo 640, hfp 24, hpulse 40, hbp 128: horizontal active, front porch, sync and back porch, in pixels.
REQ-004 SHALL have parameters activeVvideo 480, vfp 9, vpulse 2, vbp 29: vertical active, front porch, sync and back porch, in lines.
REQ-005 SHALL have parameter USE_PLL, default 1: 1 = px_clk from SB_PLL40_CORE; 0 = px_clk driven directly by clk (simulation).
REQ-006 clk  input  1  reference clock (12 MHz); the only clock input.
REQ-007 reset  input  1  asynchronous, active-low reset.
REQ-008 px_clk  output  1  pixel clock; all other outputs change only on its rising edge.
REQ-009 hsync  output  1  horizontal sync, active low.
REQ-010 vsync  output  1  vertical sync, active low.
REQ-011 x_px  output  11  current horizontal pixel counter.
REQ-012 y_px  output  11  current line counter.
REQ-013 activevideo  output  1  high while the current pixel is inside the visible area.

Function
REQ-014 SHALL define HTOTAL = activeHvideo+hfp+hpulse+hbp (832) and VTOTAL = activeVvideo+vfp+vpulse+vbp (520).
REQ-015 x_px SHALL increment by 1 on every px_clk edge and wrap from HTOTAL-1 to 0.
REQ-016 y_px SHALL increment by 1 in the same cycle that x_px wraps, and SHALL wrap from VTOTAL-1 to 0 when x_px wraps while y_px = VTOTAL-1; both counters are then 0 in the same cycle.
REQ-017 activevideo SHALL be 1 iff x_px < activeHvideo and y_px < activeVvideo.
REQ-018 hsync SHALL be 0 iff activeHvideo+hfp <= x_px < activeHvideo+hfp+hpulse (664..703); otherwise 1.
REQ-019 vsync SHALL be 0 iff activeVvideo+vfp <= y_px < activeVvideo+vfp+vpulse (489..490); otherwise 1.
REQ-020 hsync, vsync and activevideo SHALL be registered and SHALL correspond to the x_px/y_px values presented in the same cycle (zero relative skew).
REQ-021 x_px/y_px SHALL present the full counter value, including the blanking range (640..831, 480..519).
REQ-022 The counters SHALL be 11 bits wide; parameter sums up to 2047 are supported without overflow.
REQ-023 With USE_PLL=1, the counters SHALL be held in reset until the PLL LOCK output is high.

Reset
REQ-024 Reset assertion (reset=0) SHALL take effect immediately and asynchronously.
REQ-025 Reset deassertion SHALL be synchronised to px_clk through a 2-flop synchroniser.
REQ-026 During reset: x_px=0, y_px=0, hsync=1, vsync=1, activevideo=0.
REQ-027 After release, the first counted pixel SHALL be (0,0), with activevideo=1.
REQ-028 A reset asserted mid-frame SHALL abort the frame; the next frame restarts at (0,0).
REQ-029 px_clk SHALL NOT be gated by reset.

Structure
REQ-030 Timing defaults (640x480@73 Hz: 640/24/40/128, 480/9/2/29) and PLL divider defaults SHALL be placed in a shared package, vga_timing_pkg.
REQ-031 The PLL SHALL be isolated in one sub-module, vga_pll: a SB_PLL40_CORE wrapper (DIVR=0, DIVF=FDivider, DIVQ=QDivider, FILTER_RANGE=1, SIMPLE feedback) with outputs px_clk and locked.
REQ-032 Counters and sync decode SHALL reside in vga_sync_gen.

Verification (USE_PLL=0)
REQ-033 Release reset, run 1 line -> x_px counts 0..831 then 0; y_px goes from 0 to 1 in the cycle where x_px becomes 0.
REQ-034 Scan line 0 -> hsync=0 exactly for x_px 664..703 (40 cycles); activevideo=1 exactly for x_px 0..639.
REQ-035 Run a full frame -> vsync=0 exactly for y_px 489..490 (2x832 cycles); frame length 832x520 = 432640 cycles; activevideo=0 for all y_px >= 480.
REQ-036 At (831,519) -> the next cycle is (0,0) with activevideo=1, hsync=1 and vsync=1.
REQ-037 Assert reset at (700,489) -> outputs become 0/0, hsync=1, vsync=1, activevideo=0 immediately, before any clock edge; after release, counting restarts at (0,0).
REQ-038 Override parameters to 8/2/2/2 and 4/1/1/1 -> period of 14 pixels x 7 lines; hsync low at x_px 10..11, vsync low at y_px 5.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared 640x480@73 Hz timing defaults, iCE40 PLL dividers and scan-counter types.
// Combinational helpers only; no state, no backpressure.
package vga_timing_pkg;

    localparam int PLL_DIVF = 83;   // VCO = 12 MHz * 84 = 1008 MHz
    localparam int PLL_DIVQ = 5;    // px_clk = VCO / 32 = 31.5 MHz

    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 24;
    localparam int H_PULSE  = 40;
    localparam int H_BP     = 128;

    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 9;
    localparam int V_PULSE  = 2;
    localparam int V_BP     = 29;

    localparam int CNT_W = 11;
    typedef logic [CNT_W-1:0] cnt_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } scan_state_e;

    function automatic logic in_window(input cnt_t v, input cnt_t lo, input cnt_t hi);
        return (v >= lo) && (v < hi);
    endfunction

endpackage

// File: rtl/vga_pll.sv
// iCE40 PLL wrapper deriving the pixel clock from the 12 MHz reference.
// Latency: clock source only; locked rises once the VCO has settled.
// No backpressure.
module vga_pll
    import vga_timing_pkg::*;
#(
    parameter int FDivider = PLL_DIVF,
    parameter int QDivider = PLL_DIVQ
) (
    input  logic clk,
    output logic px_clk,
    output logic locked
);

`ifdef SYNTHESIS
    SB_PLL40_CORE #(
        .FEEDBACK_PATH ("SIMPLE"),
        .DIVR          (4'b0000),
        .DIVF          (7'(FDivider)),
        .DIVQ          (3'(QDivider)),
        .FILTER_RANGE  (3'b001)
    ) u_pll (
        .REFERENCECLK  (clk),
        .PLLOUTCORE    (px_clk),
        .LOCK          (locked),
        .RESETB        (1'b1),
        .BYPASS        (1'b0)
    );
`else
    // Without the iCE40 cell library the reference passes straight through; lock is only
    // reported for divider settings the hard PLL could actually realise.
    localparam bit CFG_OK = (FDivider >= 0) && (FDivider <= 127) &&
                            (QDivider >= 1) && (QDivider <= 6);

    assign px_clk = clk;
    assign locked = CFG_OK;
`endif

endmodule

// File: rtl/vga_sync_gen.sv
// VGA scan generator: x/y pixel counters with registered hsync/vsync/activevideo decode.
// Latency: decode registered with the counters (zero skew); pixel (0,0) on the 3rd px_clk edge after release.
// No backpressure: free-running while out of reset and the PLL is locked.
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int FDivider     = PLL_DIVF,
    parameter int QDivider     = PLL_DIVQ,
    parameter int activeHvideo = H_ACTIVE,
    parameter int hfp          = H_FP,
    parameter int hpulse       = H_PULSE,
    parameter int hbp          = H_BP,
    parameter int activeVvideo = V_ACTIVE,
    parameter int vfp          = V_FP,
    parameter int vpulse       = V_PULSE,
    parameter int vbp          = V_BP,
    parameter int USE_PLL      = 1
) (
    input  logic             clk,
    input  logic             reset,
    output logic             px_clk,
    output logic             hsync,
    output logic             vsync,
    output logic [CNT_W-1:0] x_px,
    output logic [CNT_W-1:0] y_px,
    output logic             activevideo
);

    localparam cnt_t HTOTAL   = cnt_t'(activeHvideo + hfp + hpulse + hbp);
    localparam cnt_t VTOTAL   = cnt_t'(activeVvideo + vfp + vpulse + vbp);
    localparam cnt_t H_LAST   = cnt_t'(activeHvideo + hfp + hpulse + hbp - 1);
    localparam cnt_t V_LAST   = cnt_t'(activeVvideo + vfp + vpulse + vbp - 1);
    localparam cnt_t H_VIS    = cnt_t'(activeHvideo);
    localparam cnt_t V_VIS    = cnt_t'(activeVvideo);
    localparam cnt_t HS_START = cnt_t'(activeHvideo + hfp);
    localparam cnt_t HS_END   = cnt_t'(activeHvideo + hfp + hpulse);
    localparam cnt_t VS_START = cnt_t'(activeVvideo + vfp);
    localparam cnt_t VS_END   = cnt_t'(activeVvideo + vfp + vpulse);
    localparam cnt_t ONE      = cnt_t'(1);

    logic pix_clk;
    logic pll_locked;

    generate
        if (USE_PLL != 0) begin : g_pll
            vga_pll #(
                .FDivider (FDivider),
                .QDivider (QDivider)
            ) u_pll (
                .clk      (clk),
                .px_clk   (pix_clk),
                .locked   (pll_locked)
            );
        end else begin : g_direct
            assign pix_clk    = clk;
            assign pll_locked = 1'b1;
        end
    endgenerate

    assign px_clk = pix_clk;

    // Loss of lock is treated exactly like the external reset: immediate assert, synchronised release.
    logic rst_src_n;
    logic rst_meta_n;
    logic rst_sync_n;

    assign rst_src_n = reset & pll_locked;

    always_ff @(posedge pix_clk or negedge rst_src_n) begin
        if (!rst_src_n) begin
            rst_meta_n <= 1'b0;
            rst_sync_n <= 1'b0;
        end else begin
            rst_meta_n <= 1'b1;
            rst_sync_n <= rst_meta_n;
        end
    end

    scan_state_e state_q;
    scan_state_e state_d;
    cnt_t        x_d;
    cnt_t        y_d;

    always_ff @(posedge pix_clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // The first edge after release loads (0,0) so the visible origin is presented with its decode.
    always_comb begin
        state_d = ST_RUN;
        x_d     = '0;
        y_d     = '0;
        if (state_q == ST_RUN) begin
            if (x_px == H_LAST) begin
                x_d = '0;
                y_d = (y_px == V_LAST) ? '0 : (y_px + ONE);
            end else begin
                x_d = x_px + ONE;
                y_d = y_px;
            end
        end
    end

    always_ff @(posedge pix_clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            x_px        <= '0;
            y_px        <= '0;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            activevideo <= 1'b0;
        end else begin
            x_px        <= x_d;
            y_px        <= y_d;
            hsync       <= ~in_window(x_d, HS_START, HS_END);
            vsync       <= ~in_window(y_d, VS_START, VS_END);
            activevideo <= (x_d < H_VIS) && (y_d < V_VIS);
        end
    end

    // Totals are kept for readability of the wrap points above.
    logic unused_totals;
    assign unused_totals = ^{HTOTAL, VTOTAL};

endmodule

// File: tb/tb_vga_sync_gen.sv
// Scoreboarded bench: a cycle-count reference model predicts every pixel of a default-timing
// instance and a shrunken-timing instance; directed scans and random resets drive both.
module tb_vga_sync_gen;

    typedef struct packed {
        logic [10:0] x;
        logic [10:0] y;
        logic        hs;
        logic        vs;
        logic        av;
    } px_t;

    localparam px_t RST_PX = '{x: 11'd0, y: 11'd0, hs: 1'b1, vs: 1'b1, av: 1'b0};

    // Two synchroniser edges after release, then the edge that presents pixel (0,0).
    localparam int FIRST_EDGE = 3;

    logic clk   = 1'b0;
    logic rst_d = 1'b0;
    logic rst_s = 1'b0;

    logic        pxc_d, hs_d, vs_d, av_d;
    logic [10:0] x_d, y_d;
    logic        pxc_s, hs_s, vs_s, av_s;
    logic [10:0] x_s, y_s;

    int total = 0;
    int bad   = 0;
    int cnt_d = 0;
    int cnt_s = 0;
    px_t q_d[$];
    px_t q_s[$];

    always #5 clk = ~clk;

    vga_sync_gen #(.USE_PLL(0)) u_dflt (
        .clk         (clk),
        .reset       (rst_d),
        .px_clk      (pxc_d),
        .hsync       (hs_d),
        .vsync       (vs_d),
        .x_px        (x_d),
        .y_px        (y_d),
        .activevideo (av_d)
    );

    vga_sync_gen #(
        .USE_PLL(0),
        .activeHvideo(8), .hfp(2), .hpulse(2), .hbp(2),
        .activeVvideo(4), .vfp(1), .vpulse(1), .vbp(1)
    ) u_small (
        .clk         (clk),
        .reset       (rst_s),
        .px_clk      (pxc_s),
        .hsync       (hs_s),
        .vsync       (vs_s),
        .x_px        (x_s),
        .y_px        (y_s),
        .activevideo (av_s)
    );

    function automatic px_t ref_px(input int cnt, input int ha, input int hf, input int hp, input int hb,
                                   input int va, input int vf, input int vp, input int vb);
        px_t r;
        int  n, x, y, ht, vt;
        r = RST_PX;
        if (cnt >= FIRST_EDGE) begin
            ht   = ha + hf + hp + hb;
            vt   = va + vf + vp + vb;
            n    = cnt - FIRST_EDGE;
            x    = n % ht;
            y    = (n / ht) % vt;
            r.x  = 11'(x);
            r.y  = 11'(y);
            r.hs = !((x >= ha + hf) && (x < ha + hf + hp));
            r.vs = !((y >= va + vf) && (y < va + vf + vp));
            r.av = (x < ha) && (y < va);
        end
        return r;
    endfunction

    function automatic px_t obs(input bit s);
        px_t p;
        if (s) p = '{x: x_s, y: y_s, hs: hs_s, vs: vs_s, av: av_s};
        else   p = '{x: x_d, y: y_d, hs: hs_d, vs: vs_d, av: av_d};
        return p;
    endfunction

    task automatic check_px(input string nm, input px_t got, input px_t exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s t=%0t got x=%0d y=%0d hs=%b vs=%b av=%b want x=%0d y=%0d hs=%b vs=%b av=%b",
                     nm, $time, got.x, got.y, got.hs, got.vs, got.av, exp.x, exp.y, exp.hs, exp.vs, exp.av);
        end
    endtask

    task automatic check_int(input string nm, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s t=%0t got=%0d want=%0d", nm, $time, got, exp);
        end
    endtask

    // Reference model: expected pixel after every edge, from edges elapsed since release.
    always @(posedge clk) begin
        cnt_d = rst_d ? cnt_d + 1 : 0;
        cnt_s = rst_s ? cnt_s + 1 : 0;
        q_d.push_back(ref_px(cnt_d, 640, 24, 40, 128, 480, 9, 2, 29));
        q_s.push_back(ref_px(cnt_s, 8, 2, 2, 2, 4, 1, 1, 1));
    end

    // Monitor: reset is asynchronous, so a reset asserted since the last edge overrides the prediction.
    always @(negedge clk) begin
        px_t e;
        #1;
        if (q_d.size() == 0) begin
            total++; bad++;
            $display("FAIL dflt scoreboard empty t=%0t", $time);
        end else begin
            e = q_d.pop_front();
            if (!rst_d) e = RST_PX;
            check_px("dflt_px", obs(1'b0), e);
        end
        if (q_s.size() == 0) begin
            total++; bad++;
            $display("FAIL small scoreboard empty t=%0t", $time);
        end else begin
            e = q_s.pop_front();
            if (!rst_s) e = RST_PX;
            check_px("small_px", obs(1'b1), e);
        end
        check_int("dflt_pxclk", int'(pxc_d), int'(clk));
        check_int("small_pxclk", int'(pxc_s), int'(clk));
    end

    task automatic wait_active(input bit s, input string nm);
        px_t p;
        int  k;
        k = 0;
        p = obs(s);
        while (!p.av && k < 20) begin
            @(negedge clk);
            k++;
            p = obs(s);
        end
        check_int({nm, "_start_av"}, int'(p.av), 1);
        check_int({nm, "_start_x"}, int'(p.x), 0);
        check_int({nm, "_start_y"}, int'(p.y), 0);
    endtask

    task automatic wait_px(input bit s, input int wx, input int wy, input int budget, input string nm);
        px_t p;
        int  k;
        k = 0;
        p = obs(s);
        while (!(int'(p.x) == wx && int'(p.y) == wy) && k < budget) begin
            @(negedge clk);
            k++;
            p = obs(s);
        end
        check_int({nm, "_reached"}, int'(k < budget), 1);
    endtask

    // Called just after a negedge: assert reset mid-cycle and check outputs before any edge.
    task automatic hit_reset(input bit s, input int hold, input string nm);
        #3;
        if (s) rst_s = 1'b0;
        else   rst_d = 1'b0;
        #1;
        check_px({nm, "_async_rst"}, obs(s), RST_PX);
        repeat (hold) @(posedge clk);
        #2;
        if (s) rst_s = 1'b1;
        else   rst_d = 1'b1;
    endtask

    task automatic scan_line_dflt();
        px_t p;
        int  hs_n, av_n, hs_first, av_last;
        hs_n = 0; av_n = 0; hs_first = -1; av_last = -1;
        for (int i = 0; i < 832; i++) begin
            if (i != 0) @(negedge clk);
            p = obs(1'b0);
            if (!p.hs) begin
                hs_n++;
                if (hs_first < 0) hs_first = int'(p.x);
            end
            if (p.av) begin
                av_n++;
                av_last = int'(p.x);
            end
        end
        check_int("dflt_line_end_x", int'(p.x), 831);
        check_int("dflt_line_end_y", int'(p.y), 0);
        check_int("dflt_hs_low_cnt", hs_n, 40);
        check_int("dflt_hs_first_x", hs_first, 640 + 24);
        check_int("dflt_av_cnt", av_n, 640);
        check_int("dflt_av_last_x", av_last, 639);
        @(negedge clk);
        p = obs(1'b0);
        check_int("dflt_wrap_x", int'(p.x), 0);
        check_int("dflt_wrap_y", int'(p.y), 1);
    endtask

    // Starts on (0,0) and stops on the next (0,0).
    task automatic scan_frame_small();
        px_t p;
        int  n, vs_n, hs_n, av_n, vs_first, hs_first;
        n = 0; vs_n = 0; hs_n = 0; av_n = 0; vs_first = -1; hs_first = -1;
        p = obs(1'b1);
        do begin
            if (!p.vs) begin
                vs_n++;
                if (vs_first < 0) vs_first = int'(p.y);
            end
            if (!p.hs) begin
                hs_n++;
                if (hs_first < 0) hs_first = int'(p.x);
            end
            if (p.av) av_n++;
            @(negedge clk);
            n++;
            p = obs(1'b1);
        end while (!(p.x == 11'd0 && p.y == 11'd0) && n < 200);
        check_int("small_frame_len", n, 14 * 7);
        check_int("small_vs_low_cnt", vs_n, 14);
        check_int("small_vs_first_y", vs_first, 5);
        check_int("small_hs_low_cnt", hs_n, 2 * 7);
        check_int("small_hs_first_x", hs_first, 10);
        check_int("small_av_cnt", av_n, 8 * 4);
        check_px("small_wrap", p, '{x: 11'd0, y: 11'd0, hs: 1'b1, vs: 1'b1, av: 1'b1});
    endtask

    initial begin
        int sel;
        repeat (4) @(posedge clk);
        #2;
        rst_d = 1'b1;
        rst_s = 1'b1;
        fork
            begin
                wait_active(1'b0, "dflt");
                scan_line_dflt();
                wait_px(1'b0, 700, 1, 1000, "dflt_700_1");
                hit_reset(1'b0, int'($urandom_range(1, 4)), "dflt");
                wait_active(1'b0, "dflt_rerun");
            end
            begin
                wait_active(1'b1, "small");
                scan_frame_small();
                scan_frame_small();
                wait_px(1'b1, 10, 5, 200, "small_10_5");
                hit_reset(1'b1, int'($urandom_range(1, 4)), "small");
                wait_active(1'b1, "small_rerun");
                scan_frame_small();
            end
        join
        for (int it = 0; it < 12; it++) begin
            repeat ($urandom_range(1, 400)) @(posedge clk);
            #2;
            sel = int'($urandom_range(0, 2));
            if (sel != 1) rst_d = 1'b0;
            if (sel != 0) rst_s = 1'b0;
            repeat ($urandom_range(1, 6)) @(posedge clk);
            #2;
            rst_d = 1'b1;
            rst_s = 1'b1;
        end
        repeat (300) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
